uart_report_sched: RTL and testbench

Scheduler that turns a snapshot of the six cache event counters into human-readable ASCII report lines and feeds them to `uart_tx` one byte at a time. It sits between the cache performance counters and the UART transmitter, and owns the transmitter's `din`/`tx_start` inputs. On a report request it freezes all counters, then serialises each counter as one line of the form label, colon, hex value, CR/LF. Requests that arrive while a report is in progress are held and serviced afterwards.

---
 rtl/uart_report_pkg.sv | 38 +++
 rtl/uart_report_sched_if.sv | 29 ++
 rtl/hex_nibble_ascii.sv | 10 +
 rtl/uart_report_sched.sv | 205 ++++++++++++++++++++
 tb/tb_uart_report_sched.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_report_pkg.sv
// Shared definitions for the cache counter report scheduler: FSM and
// byte-emission encodings, fixed ASCII characters and the line label ROM.
package uart_report_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNAP,
        ST_LABEL,
        ST_COLON,
        ST_HEX,
        ST_CR,
        ST_LF,
        ST_FIN
    } state_t;

    typedef enum logic [1:0] {
        EM_ISSUE,
        EM_WAIT_LO,
        EM_WAIT_HI
    } emit_t;

    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int unsigned LABEL_LEN  = 4;
    localparam int unsigned LABEL_SRCS = 6;

    // Source k occupies entry k; character index 3 is the first character sent.
    localparam logic [LABEL_SRCS-1:0][LABEL_LEN-1:0][7:0] LABEL_ROM =
        {"2REQ", "2MIS", "DREQ", "DMIS", "IREQ", "IMIS"};

    // Label character `pos` (0 = first transmitted) of source `src`.
    function automatic logic [7:0] label_byte(input logic [2:0] src, input logic [1:0] pos);
        return LABEL_ROM[src][2'd3 - pos];
    endfunction

endpackage

// File: rtl/uart_report_sched_if.sv
// Bus between the report scheduler and its environment.
//   report_req : report request (rising edge)
//   cnt_in     : N_SRC counters, source k at [k*CNT_W +: CNT_W]
//   tx_ready   : UART transmitter idle
//   tx_byte    : byte to transmit (uart_tx.din)
//   tx_start   : one-cycle start pulse (uart_tx.tx_start)
//   busy/done  : report in progress / report finished pulse
interface uart_report_sched_if #(
    parameter int unsigned N_SRC = 6,
    parameter int unsigned CNT_W = 32
);
    logic                   report_req;
    logic [N_SRC*CNT_W-1:0] cnt_in;
    logic                   tx_ready;
    logic [7:0]             tx_byte;
    logic                   tx_start;
    logic                   busy;
    logic                   done;

    modport master (
        input  report_req, cnt_in, tx_ready,
        output tx_byte, tx_start, busy, done
    );

    modport slave (
        output report_req, cnt_in, tx_ready,
        input  tx_byte, tx_start, busy, done
    );
endinterface

// File: rtl/hex_nibble_ascii.sv
// Maps one nibble to its uppercase ASCII hex digit.
//   nib   : 4-bit value
//   ascii : '0'..'9' / 'A'..'F'
module hex_nibble_ascii (
    input  logic [3:0] nib,
    output logic [7:0] ascii
);
    // 'A' - 10 = 0x37
    assign ascii = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
endmodule

// File: rtl/uart_report_sched.sv
// Snapshots the cache event counters on a report request and streams one
// "LABL:HHHHHHHH\r\n" line per source to the UART transmitter, one byte per
// tx_ready handshake. A request arriving mid-report is held (1 deep).
//   clk, rstn : clock, async active-low reset
//   bus       : report_req/cnt_in/tx_ready in; tx_byte/tx_start/busy/done out
module uart_report_sched
    import uart_report_pkg::*;
#(
    parameter int unsigned N_SRC = 6,
    parameter int unsigned CNT_W = 32
) (
    input  logic                clk,
    input  logic                rstn,
    uart_report_sched_if.master bus
);
    localparam int unsigned DIGITS = CNT_W / 4;
    localparam int unsigned SRC_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int unsigned POS_W  = (DIGITS > LABEL_LEN) ? $clog2(DIGITS) : $clog2(LABEL_LEN);

    typedef logic [N_SRC-1:0][DIGITS-1:0][3:0] snap_t;

    state_t             state, state_d;
    emit_t              emit, emit_d;
    logic [SRC_W-1:0]   src, src_d;
    logic [POS_W-1:0]   pos, pos_d;
    snap_t              snap, snap_d;
    logic               pending, pending_d;
    logic               req_q;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic               tx_start_q, tx_start_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               req_edge_c;
    logic               adv_c;
    logic [3:0]         nib_c;
    logic [7:0]         hex_char_c;
    logic [7:0]         cur_byte_c;

    assign bus.tx_byte  = tx_byte_q;
    assign bus.tx_start = tx_start_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

    assign req_edge_c = bus.report_req & ~req_q;

    // Current hex digit, MSB first
    assign nib_c = snap[src][POS_W'(DIGITS - 1) - pos];

    hex_nibble_ascii u_hex (
        .nib   (nib_c),
        .ascii (hex_char_c)
    );

    // Byte belonging to the current line position
    always_comb begin
        cur_byte_c = ASCII_LF;
        case (state)
            ST_LABEL: cur_byte_c = label_byte(3'(src), pos[1:0]);
            ST_COLON: cur_byte_c = ASCII_COLON;
            ST_HEX:   cur_byte_c = hex_char_c;
            ST_CR:    cur_byte_c = ASCII_CR;
            default:  cur_byte_c = ASCII_LF;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            emit       <= EM_ISSUE;
            src        <= '0;
            pos        <= '0;
            snap       <= '0;
            pending    <= 1'b0;
            req_q      <= 1'b0;
            tx_byte_q  <= 8'h00;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_d;
            emit       <= emit_d;
            src        <= src_d;
            pos        <= pos_d;
            snap       <= snap_d;
            pending    <= pending_d;
            req_q      <= bus.report_req;
            tx_byte_q  <= tx_byte_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state;
        emit_d     = emit;
        src_d      = src;
        pos_d      = pos;
        snap_d     = snap;
        pending_d  = pending;
        tx_byte_d  = tx_byte_q;
        tx_start_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        adv_c      = 1'b0;

        // FIN consumes requests itself, so only mid-report edges are held
        if (req_edge_c && state != ST_IDLE && state != ST_FIN) begin
            pending_d = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (req_edge_c) begin
                    state_d = ST_SNAP;
                    busy_d  = 1'b1;
                end
            end
            ST_SNAP: begin
                snap_d  = bus.cnt_in;
                src_d   = '0;
                pos_d   = '0;
                state_d = ST_LABEL;
                emit_d  = EM_ISSUE;
                // First label byte is constant, so it can be issued from here
                if (bus.tx_ready) begin
                    tx_start_d = 1'b1;
                    tx_byte_d  = label_byte(3'd0, 2'd0);
                    emit_d     = EM_WAIT_LO;
                end
            end
            ST_FIN: begin
                pending_d = 1'b0;
                if (pending || req_edge_c) begin
                    state_d = ST_SNAP;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                case (emit)
                    EM_ISSUE: begin
                        if (bus.tx_ready) begin
                            tx_start_d = 1'b1;
                            tx_byte_d  = cur_byte_c;
                            emit_d     = EM_WAIT_LO;
                        end
                    end
                    EM_WAIT_LO: begin
                        if (!bus.tx_ready) emit_d = EM_WAIT_HI;
                    end
                    EM_WAIT_HI: begin
                        if (bus.tx_ready) begin
                            emit_d = EM_ISSUE;
                            adv_c  = 1'b1;
                        end
                    end
                    default: emit_d = EM_ISSUE;
                endcase

                if (adv_c) begin
                    case (state)
                        ST_LABEL: begin
                            if (pos == POS_W'(LABEL_LEN - 1)) begin
                                pos_d   = '0;
                                state_d = ST_COLON;
                            end else begin
                                pos_d = pos + POS_W'(1);
                            end
                        end
                        ST_COLON: begin
                            pos_d   = '0;
                            state_d = ST_HEX;
                        end
                        ST_HEX: begin
                            if (pos == POS_W'(DIGITS - 1)) begin
                                pos_d   = '0;
                                state_d = ST_CR;
                            end else begin
                                pos_d = pos + POS_W'(1);
                            end
                        end
                        ST_CR: state_d = ST_LF;
                        ST_LF: begin
                            if (src == SRC_W'(N_SRC - 1)) begin
                                state_d = ST_FIN;
                                done_d  = 1'b1;
                                busy_d  = 1'b0;
                            end else begin
                                src_d   = src + SRC_W'(1);
                                state_d = ST_LABEL;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
        endcase
    end

endmodule

// File: tb/tb_uart_report_sched.sv
// Directed bench for uart_report_sched with a simple UART model that drops
// tx_ready for 3 cycles after every start pulse.
module tb_uart_report_sched;

    logic clk;
    logic rstn;
    logic stall;
    int   ucnt;

    int   tests;
    int   fails;
    int   done_cnt;
    int   dbl_err;
    int   rdy_err;
    int   low_run;
    int   last_gap;
    int   stall_bad;
    logic prev_start;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    string      lbl[6] = '{"IMIS", "IREQ", "DMIS", "DREQ", "2MIS", "2REQ"};

    uart_report_sched_if #(.N_SRC(6), .CNT_W(32)) bus ();

    uart_report_sched #(.N_SRC(6), .CNT_W(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART model: busy for 3 cycles after each start
    assign bus.tx_ready = (ucnt == 0) && !stall;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) ucnt <= 0;
        else if (bus.tx_start) ucnt <= 3;
        else if (ucnt > 0) ucnt <= ucnt - 1;
    end

    // Capture transmitted bytes and protocol observations
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.tx_start) begin
                got_q.push_back(bus.tx_byte);
                if (prev_start) dbl_err++;
                if (!bus.tx_ready) rdy_err++;
            end
            prev_start = bus.tx_start;
            if (bus.done) done_cnt++;
            if (bus.busy) begin
                if (low_run > 0) last_gap = low_run;
                low_run = 0;
            end else begin
                low_run++;
            end
        end else begin
            prev_start = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_req();
        bus.report_req = 1'b1;
        step(1);
        bus.report_req = 1'b0;
    endtask

    task automatic add_report(input logic [191:0] cv);
        logic [3:0] n;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(lbl[k][i]);
            exp_q.push_back(8'h3A);
            for (int d = 7; d >= 0; d--) begin
                n = cv[k*32 + d*4 +: 4];
                if (n < 4'd10) exp_q.push_back(8'h30 + 8'(n));
                else exp_q.push_back(8'h41 + 8'(n) - 8'd10);
            end
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic clear_obs();
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            step(1);
            n++;
        end
        chk({tag, "_done_timeout"}, done_cnt, target);
    endtask

    task automatic wait_bytes(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (got_q.size() < target && n < budget) begin
            step(1);
            n++;
        end
        chk({tag, "_byte_timeout"}, got_q.size(), target);
    endtask

    task automatic check_report(input string tag);
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
        end
    endtask

    logic [191:0] v1;
    logic [191:0] v2;

    initial begin
        tests = 0; fails = 0; done_cnt = 0; dbl_err = 0; rdy_err = 0;
        low_run = 0; last_gap = 0; stall_bad = 0; prev_start = 1'b0;
        stall = 1'b0;
        rstn = 1'b0;
        bus.report_req = 1'b0;
        bus.cnt_in = '0;

        // Reset values
        step(3);
        chk("rst_tx_start", bus.tx_start, 1'b0);
        chk("rst_tx_byte", bus.tx_byte, 8'h00);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        rstn = 1'b1;
        step(3);
        chk("idle_busy", bus.busy, 1'b0);

        // Zero counters, with request latency
        clear_obs();
        add_report('0);
        bus.report_req = 1'b1;
        step(1);
        bus.report_req = 1'b0;
        chk("lat_busy_snap", bus.busy, 1'b1);
        chk("lat_no_start_snap", bus.tx_start, 1'b0);
        step(1);
        chk("lat_first_start", bus.tx_start, 1'b1);
        chk("lat_first_byte", bus.tx_byte, 8'h49);
        wait_done("zero", 1, 2000);
        step(1);
        chk("zero_done_pulse_len", bus.done, 1'b0);
        chk("zero_busy_after", bus.busy, 1'b0);
        step(5);
        check_report("zero");
        chk("zero_done_cnt", done_cnt, 1);

        // Nonzero counters
        clear_obs();
        bus.cnt_in = {32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000000A5};
        add_report(bus.cnt_in);
        pulse_req();
        wait_done("val", 1, 2000);
        step(5);
        check_report("val");

        // Counter change mid-report does not reach the output
        clear_obs();
        v1 = {32'h0000FFFF, 32'h89ABCDEF, 32'h01234567, 32'h11111111, 32'hCAFEF00D, 32'h00000001};
        v2 = {32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888, 32'h99999999, 32'hAAAAAAAA};
        bus.cnt_in = v1;
        add_report(v1);
        pulse_req();
        step(100);
        bus.cnt_in = v2;
        wait_done("snap", 1, 2000);
        step(5);
        check_report("snap");

        // Two edges during one report: one extra report, busy gap of one cycle
        clear_obs();
        add_report(v2);
        add_report(v2);
        low_run = 0;
        last_gap = 0;
        pulse_req();
        step(5);
        pulse_req();
        step(20);
        pulse_req();
        wait_done("pend", 2, 3000);
        step(20);
        check_report("pend");
        chk("pend_done_cnt", done_cnt, 2);
        chk("pend_busy_gap", last_gap, 1);

        // tx_ready held low in the middle of a hex field
        clear_obs();
        v1 = {32'h0, 32'h0, 32'h0, 32'h0, 32'h12345678, 32'h0};
        bus.cnt_in = v1;
        add_report(v1);
        pulse_req();
        wait_bytes("stall", 21, 500);
        stall = 1'b1;
        stall_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1);
            if (bus.tx_byte !== exp_q[20]) stall_bad++;
        end
        chk("stall_no_start", got_q.size(), 21);
        chk("stall_byte_stable", stall_bad, 0);
        chk("stall_byte_value", bus.tx_byte, 8'h31);
        stall = 1'b0;
        wait_done("stall", 1, 2000);
        step(5);
        check_report("stall");

        // Reset in the middle of byte 40, then a clean restart
        clear_obs();
        bus.cnt_in = v2;
        pulse_req();
        wait_bytes("rst", 40, 1000);
        rstn = 1'b0;
        #1;
        chk("midrst_tx_start", bus.tx_start, 1'b0);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_tx_byte", bus.tx_byte, 8'h00);
        chk("midrst_done", bus.done, 1'b0);
        step(3);
        rstn = 1'b1;
        step(3);
        clear_obs();
        add_report(v2);
        pulse_req();
        wait_done("restart", 1, 2000);
        step(5);
        check_report("restart");

        chk("double_start", dbl_err, 0);
        chk("start_while_not_ready", rdy_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
